// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame geometry and default baud divisor.
// Used by both the receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output bundle of the UART receiver: single-entry valid/ready.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit oversampling of a synchronized rx line,
// single-entry byte output with frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master rxo,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF =
    TW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST =
    3'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q & ~rxo.rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tmr_q == T_HALF) begin
          tmr_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr_q == T_LAST) begin
          tmr_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (tmr_q == T_LAST) begin
          tmr_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            // An accept in this same cycle frees the slot.
            if (!valid_q || rxo.rx_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        tmr_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rxo.rx_data  = data_q;
  assign rxo.rx_valid = valid_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Sent bytes go to a scoreboard; accepted bytes are popped and compared.
module tb_uart_rx;

  localparam int C = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rx_if rif ();

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rxo      (rif),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int vld_cyc  = 0;

  always @(negedge clk) begin
    if (rif.rx_valid && rif.rx_ready) got_q.push_back(rif.rx_data);
    if (rif.rx_valid) vld_cyc++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_bit();
    repeat (C) @(posedge clk);
    #1;
  endtask

  // Caller is aligned #1 after a posedge; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int stop_bits);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bit();
    end
    rx = stop_v;
    repeat (stop_bits) wait_bit();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    rif.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (rif.rx_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid: got %b want 0", rif.rx_valid);
    end
    vec++;
    if (rif.rx_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_data: got %02h want 00", rif.rx_data);
    end
    vec++;
    if ({busy, frame_err, overrun} !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags: got %b want 000",
               {busy, frame_err, overrun});
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_latency();
    int lat;
    int f0, o0;
    logic [7:0] d_at;
    logic [7:0] e, g;
    lat = -1;
    d_at = 8'h00;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rif.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(posedge clk);
          #1;
          if (rif.rx_valid) begin
            lat = i;
            d_at = rif.rx_data;
            break;
          end
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (lat != 155) begin
      errs++;
      $display("FAIL latency: got %0d want 155", lat);
    end
    vec++;
    if (d_at !== 8'hA5) begin
      errs++;
      $display("FAIL a5_data: got %02h want a5", d_at);
    end
    vec++;
    if (ferr_cnt != f0 || ovr_cnt != o0) begin
      errs++;
      $display("FAIL a5_flags: got ferr %0d ovr %0d want 0 0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (got_q.size() == 0) begin
        errs++;
        $display("FAIL a5_sb: got none want %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errs++;
          $display("FAIL a5_sb: got %02h want %02h", g, e);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int f0, v0;
    logic b_mid;
    f0 = ferr_cnt;
    v0 = vld_cyc;
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    b_mid = busy;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    vec++;
    if (b_mid !== 1'b1) begin
      errs++;
      $display("FAIL glitch_start: busy %b want 1", b_mid);
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL glitch_idle: busy %b want 0", busy);
    end
    vec++;
    if (vld_cyc != v0 || ferr_cnt != f0) begin
      errs++;
      $display("FAIL glitch_flags: got vld %0d ferr %0d want 0 0",
               vld_cyc - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int f0, v0;
    logic [7:0] e, g;
    f0 = ferr_cnt;
    v0 = vld_cyc;
    rif.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, 3);
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL ferr_busy_low: got %b want 1", busy);
    end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL ferr_busy_high: got %b want 0", busy);
    end
    vec++;
    if (ferr_cnt - f0 != 1) begin
      errs++;
      $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt - f0);
    end
    vec++;
    if (vld_cyc != v0) begin
      errs++;
      $display("FAIL ferr_valid: got %0d cycles want 0", vld_cyc - v0);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (got_q.size() == 0) begin
        errs++;
        $display("FAIL ferr_next_sb: got none want %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errs++;
          $display("FAIL ferr_next_sb: got %02h want %02h", g, e);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int o0;
    logic [7:0] e, g;
    o0 = ovr_cnt;
    rif.rx_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    repeat (6) @(posedge clk);
    #1;
    vec++;
    if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h11) begin
      errs++;
      $display("FAIL ovr_hold: got v%b %02h want v1 11",
               rif.rx_valid, rif.rx_data);
    end
    vec++;
    if (ovr_cnt - o0 != 1) begin
      errs++;
      $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0);
    end
    rif.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    vec++;
    if (rif.rx_valid !== 1'b0) begin
      errs++;
      $display("FAIL ovr_accept: valid %b want 0", rif.rx_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (got_q.size() == 0) begin
        errs++;
        $display("FAIL ovr_sb: got none want %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errs++;
          $display("FAIL ovr_sb: got %02h want %02h", g, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int o0, v0;
    logic [7:0] pat[3];
    logic [7:0] e, g;
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h55;
    o0 = ovr_cnt;
    v0 = vld_cyc;
    rif.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1, 1);
    end
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (vld_cyc - v0 != 3) begin
      errs++;
      $display("FAIL b2b_pulses: got %0d want 3", vld_cyc - v0);
    end
    vec++;
    if (ovr_cnt != o0) begin
      errs++;
      $display("FAIL b2b_ovr: got %0d want 0", ovr_cnt - o0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (got_q.size() == 0) begin
        errs++;
        $display("FAIL b2b_sb: got none want %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errs++;
          $display("FAIL b2b_sb: got %02h want %02h", g, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [7:0] e, g;
    b = 8'h7E;
    rif.rx_ready = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (rif.rx_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre_valid: got %b want 1", rif.rx_valid);
    end
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_bit();
    end
    rx = b[4];
    repeat (8) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({rif.rx_valid, busy, frame_err, overrun} !== 4'b0000 ||
        rif.rx_data !== 8'h00) begin
      errs++;
      $display("FAIL rst_mid: got v%b b%b f%b o%b d%02h want 0000 00",
               rif.rx_valid, busy, frame_err, overrun, rif.rx_data);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rif.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (got_q.size() == 0) begin
        errs++;
        $display("FAIL rst_next_sb: got none want %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errs++;
          $display("FAIL rst_next_sb: got %02h want %02h", g, e);
        end
      end
    end
    vec++;
    if (got_q.size() != 0) begin
      errs++;
      $display("FAIL extra_bytes: got %0d want 0", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the inbound counterpart of the existing `tx` path in `top`. It oversamples the `rx` pin with the system clock, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop), and presents each byte on a single-entry valid/ready output. It sits between the board's UART RX pin and the command/control logic, enabling host configuration and loopback testing alongside the temperature-report transmitter.

## Interface

- `CLKS_PER_BIT`, default 104: system clocks per bit (12 MHz / 115200 ≈ 104); legal range 4..65535.
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`
- `rx_data`  out  8  received byte, stable while `rx_valid`=1
- `rx_valid`  out  1  byte available; held until accepted
- `rx_ready`  in  1  consumer accepts byte when `rx_valid & rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: new byte completed while previous still unaccepted
- `busy`  out  1  high whenever state ≠ IDLE

## Operation

- `rx` passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized signal `rx_s`.
- Bit timer: counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit index 0..7 (3 bits).
- States:
  - IDLE: on `rx_s`=0 → START, timer cleared.
  - START: at timer = CLKS_PER_BIT/2 - 1 (mid start bit) sample `rx_s`; 0 → DATA (timer cleared, index 0); 1 → IDLE (glitch rejected, no flags).
  - DATA: at timer = CLKS_PER_BIT-1 shift `rx_s` into shift register MSB (LSB-first reception); after index 7 → STOP.
  - STOP: at timer = CLKS_PER_BIT-1 sample `rx_s`; 1 → deliver byte, → IDLE; 0 → pulse `frame_err`, discard byte, → WAIT_HIGH.
  - WAIT_HIGH: remain until `rx_s`=1 (break/line-low), then → IDLE.
- Delivery: if `rx_valid`=0 or accepted in the same cycle, load `rx_data`, set `rx_valid`. Otherwise pulse `overrun`; old byte retained, new byte dropped.
- Acceptance `rx_valid & rx_ready` clears `rx_valid` next cycle; simultaneous accept + new delivery loads new byte, `rx_valid` stays 1, no overrun.
- Reset (any time, including mid-frame): state IDLE, sync flops 1, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, counters 0. Next frame after release received normally.

## Timing

- Sampling at mid-bit: start at CLKS_PER_BIT/2 clocks after detected falling edge; each subsequent bit CLKS_PER_BIT later.
- Latency: `rx_valid` rises CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles after the first cycle `rx_s`=0 (synchronizer adds 2 cycles from pin).
- `frame_err`/`overrun` asserted exactly one cycle, in the cycle after the stop-bit sample.
- Back-to-back frames: IDLE re-entered at stop-bit middle; a start edge half a bit later is caught. Tolerates ±4 % baud mismatch at CLKS_PER_BIT ≥ 16.
- No combinational path from `rx` to any output; `rx_ready` affects only registered state.

## Structure

- Shared package `uart_pkg`: state enum (IDLE, START, DATA, STOP, WAIT_HIGH), `DATA_BITS`=8, default `CLKS_PER_BIT` constant, shared with the transmitter.
- Sub-module `sync_2ff` (reusable 2-flop synchronizer with reset value parameter); also used for `ds18b20_dq` input sampling.

## Test plan

Benches use CLKS_PER_BIT=16.
- Send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) → `rx_data`=0xA5, `rx_valid` rises at latency 8+144+1+2 = 155 cycles after pin falls; no flags.
- 4-cycle low glitch on idle line → state returns to IDLE, no `rx_valid`, no `frame_err`.
- Frame 0x3C with stop bit driven 0 for 3 bit times → one `frame_err` pulse, `rx_valid` stays 0, `busy` until line high; following 0x81 frame received correctly.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_data`=0x11 held, one `overrun` pulse; raise `rx_ready` → `rx_valid` drops next cycle.
- `rx_ready`=1 continuously, send 0x00, 0xFF, 0x55 back-to-back → three single-cycle `rx_valid` pulses with matching data, no overrun.
- Assert `rst_n`=0 during DATA bit 4 → all outputs 0 immediately; release, send 0x7E → received as 0x7E.
